// File: rtl/player_hit_judge.sv
// Player collision judge: detects enemy-bullet overlap with the player plane,
// applies damage, and runs the ALIVE / INVULN / DEAD life cycle.
module player_hit_judge #(
    parameter int HEALTH_INIT   = 3,
    parameter int INVULN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        restart,
    input  logic [9:0]  pp_x,
    input  logic [9:0]  pp_y,
    input  logic [39:0] eb_x,
    input  logic [39:0] eb_y,
    input  logic [3:0]  eb_en,
    output logic [3:0]  eb_clr,
    output logic [2:0]  health,
    output logic        hit,
    output logic        invuln,
    output logic        flash,
    output logic        dead
);

    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_t;

    state_t      state_reg;
    logic [2:0]  health_reg;
    logic [7:0]  count_reg;
    logic [3:0]  eb_clr_reg;
    logic        hit_reg;

    logic [10:0] x_lo, x_hi, y_lo, y_hi;
    logic [3:0]  overlap;
    logic        any_overlap;

    // Hit window is 11 bits wide so neither bound can wrap around the screen edge.
    always_comb begin
        x_lo = (pp_x >= 10'd10) ? ({1'b0, pp_x} - 11'd10) : 11'd0;
        y_lo = (pp_y >= 10'd10) ? ({1'b0, pp_y} - 11'd10) : 11'd0;
        x_hi = {1'b0, pp_x} + 11'd50;
        y_hi = {1'b0, pp_y} + 11'd50;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_bullet
            logic [10:0] bx, by;
            assign bx = {1'b0, eb_x[10*gi +: 10]};
            assign by = {1'b0, eb_y[10*gi +: 10]};
            assign overlap[gi] = eb_en[gi] && (bx >= x_lo) && (bx < x_hi)
                                 && (by >= y_lo) && (by < y_hi);
        end
    endgenerate

    assign any_overlap = |overlap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ALIVE;
            health_reg <= 3'(HEALTH_INIT);
            count_reg  <= 8'd0;
            eb_clr_reg <= 4'd0;
            hit_reg    <= 1'b0;
        end else if (restart) begin
            state_reg  <= ALIVE;
            health_reg <= 3'(HEALTH_INIT);
            count_reg  <= 8'd0;
            eb_clr_reg <= 4'd0;
            hit_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ALIVE: begin
                    eb_clr_reg <= overlap;
                    hit_reg    <= any_overlap;
                    // A hit takes priority over a same-cycle tick: the timer is loaded fresh.
                    if (any_overlap) begin
                        if (health_reg <= 3'd1) begin
                            state_reg  <= DEAD;
                            health_reg <= 3'd0;
                            count_reg  <= 8'd0;
                        end else begin
                            state_reg  <= INVULN;
                            health_reg <= health_reg - 3'd1;
                            count_reg  <= 8'(INVULN_FRAMES);
                        end
                    end
                end
                INVULN: begin
                    eb_clr_reg <= overlap;
                    hit_reg    <= 1'b0;
                    if (tick) begin
                        if (count_reg <= 8'd1) begin
                            state_reg <= ALIVE;
                            count_reg <= 8'd0;
                        end else begin
                            count_reg <= count_reg - 8'd1;
                        end
                    end
                end
                default: begin
                    state_reg  <= DEAD;
                    health_reg <= 3'd0;
                    eb_clr_reg <= 4'd0;
                    hit_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign eb_clr = eb_clr_reg;
    assign hit    = hit_reg;
    assign health = health_reg;
    assign invuln = (state_reg == INVULN);
    assign dead   = (state_reg == DEAD);
    assign flash  = (state_reg == INVULN) & count_reg[2];

endmodule

// File: tb/tb_player_hit_judge.sv
// Directed bench for player_hit_judge: damage, invulnerability timer, death,
// restart priority, window clamping and asynchronous reset.
module tb_player_hit_judge;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        restart;
    logic [9:0]  pp_x, pp_y;
    logic [39:0] eb_x, eb_y;
    logic [3:0]  eb_en;
    logic [3:0]  eb_clr;
    logic [2:0]  health;
    logic        hit, invuln, flash, dead;

    int errors = 0;
    int checks = 0;

    player_hit_judge #(.HEALTH_INIT(3), .INVULN_FRAMES(60)) dut (
        .clk(clk), .rst(rst), .tick(tick), .restart(restart),
        .pp_x(pp_x), .pp_y(pp_y), .eb_x(eb_x), .eb_y(eb_y), .eb_en(eb_en),
        .eb_clr(eb_clr), .health(health), .hit(hit), .invuln(invuln),
        .flash(flash), .dead(dead)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bullet(input int i, input logic [9:0] x, input logic [9:0] y);
        eb_x[10*i +: 10] = x;
        eb_y[10*i +: 10] = y;
    endtask

    task automatic run_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 1'b0; restart = 1'b0;
        pp_x = 10'd100; pp_y = 10'd200; eb_x = '0; eb_y = '0; eb_en = 4'b0000;
        step(); step();
        checks++; if (health !== 3'd3) begin errors++; $display("FAIL reset_health got=%0d exp=3", health); end
        checks++; if ({hit, invuln, flash, dead} !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {hit, invuln, flash, dead}); end
        checks++; if (eb_clr !== 4'b0000) begin errors++; $display("FAIL reset_eb_clr got=%b exp=0000", eb_clr); end
        rst = 1'b0;
        step();
        $display("test_reset done health=%0d", health);
    endtask

    task automatic test_single_hit();
        set_bullet(0, 10'd120, 10'd230);
        eb_en = 4'b0001;
        step();
        eb_en = 4'b0000;
        checks++; if (eb_clr !== 4'b0001) begin errors++; $display("FAIL single_eb_clr got=%b exp=0001", eb_clr); end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL single_hit got=%b exp=1", hit); end
        checks++; if (health !== 3'd2) begin errors++; $display("FAIL single_health got=%0d exp=2", health); end
        checks++; if (invuln !== 1'b1) begin errors++; $display("FAIL single_invuln got=%b exp=1", invuln); end
        step();
        checks++; if ({hit, eb_clr} !== 5'b0) begin errors++; $display("FAIL single_pulse_end got=%b exp=00000", {hit, eb_clr}); end
        $display("test_single_hit done health=%0d invuln=%b", health, invuln);
    endtask

    task automatic test_invuln_timer();
        run_ticks(29);
        // counter = 31 -> bit 2 set
        checks++; if (flash !== 1'b1) begin errors++; $display("FAIL timer_flash31 got=%b exp=1", flash); end
        tick = 1'b1; eb_en = 4'b0001;
        step();
        tick = 1'b0; eb_en = 4'b0000;
        checks++; if (eb_clr !== 4'b0001) begin errors++; $display("FAIL timer_eb_clr got=%b exp=0001", eb_clr); end
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL timer_no_hit got=%b exp=0", hit); end
        checks++; if (health !== 3'd2) begin errors++; $display("FAIL timer_health got=%0d exp=2", health); end
        step();
        run_ticks(29);
        checks++; if (invuln !== 1'b1) begin errors++; $display("FAIL timer_59_invuln got=%b exp=1", invuln); end
        checks++; if (flash !== 1'b0) begin errors++; $display("FAIL timer_flash1 got=%b exp=0", flash); end
        // exit tick with an overlap: consumed but no damage
        tick = 1'b1; eb_en = 4'b0001;
        step();
        tick = 1'b0; eb_en = 4'b0000;
        checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL timer_60_exit got=%b exp=0", invuln); end
        checks++; if ({hit, health} !== {1'b0, 3'd2}) begin errors++; $display("FAIL timer_exit_nodmg got=%b/%0d exp=0/2", hit, health); end
        step();
        $display("test_invuln_timer done health=%0d invuln=%b", health, invuln);
    endtask

    task automatic test_restart_overlap();
        restart = 1'b1; eb_en = 4'b0001;
        step();
        restart = 1'b0; eb_en = 4'b0000;
        checks++; if (health !== 3'd3) begin errors++; $display("FAIL restart_ov_health got=%0d exp=3", health); end
        checks++; if ({hit, invuln, eb_clr} !== 6'b0) begin errors++; $display("FAIL restart_ov_flags got=%b exp=000000", {hit, invuln, eb_clr}); end
        step();
        $display("test_restart_overlap done health=%0d", health);
    endtask

    task automatic test_hit_tick();
        tick = 1'b1; eb_en = 4'b0001;
        step();
        tick = 1'b0; eb_en = 4'b0000;
        checks++; if ({hit, invuln, health} !== {2'b11, 3'd2}) begin errors++; $display("FAIL hittick_state got=%b%b/%0d exp=11/2", hit, invuln, health); end
        // counter 60 (bit2=1) rather than 59 (bit2=0)
        checks++; if (flash !== 1'b1) begin errors++; $display("FAIL hittick_counter60 got=%b exp=1", flash); end
        restart = 1'b1;
        step();
        restart = 1'b0;
        step();
        $display("test_hit_tick done health=%0d", health);
    endtask

    task automatic test_multi_hit();
        set_bullet(0, 10'd0,   10'd0);
        set_bullet(1, 10'd90,  10'd190);
        set_bullet(2, 10'd150, 10'd200);
        set_bullet(3, 10'd149, 10'd249);
        eb_en = 4'b1111;
        step();
        eb_en = 4'b0000;
        checks++; if (eb_clr !== 4'b1010) begin errors++; $display("FAIL multi_eb_clr got=%b exp=1010", eb_clr); end
        checks++; if (health !== 3'd2) begin errors++; $display("FAIL multi_health got=%0d exp=2", health); end
        step();
        run_ticks(60);
        checks++; if (invuln !== 1'b0) begin errors++; $display("FAIL multi_exit got=%b exp=0", invuln); end
        $display("test_multi_hit done health=%0d", health);
    endtask

    task automatic test_death();
        eb_en = 4'b0010;
        step();
        eb_en = 4'b0000;
        step();
        run_ticks(60);
        checks++; if ({invuln, health} !== {1'b0, 3'd1}) begin errors++; $display("FAIL death_pre got=%b/%0d exp=0/1", invuln, health); end
        eb_en = 4'b0010;
        step();
        checks++; if ({dead, hit, health} !== {2'b11, 3'd0}) begin errors++; $display("FAIL death_enter got=%b%b/%0d exp=11/0", dead, hit, health); end
        checks++; if (eb_clr !== 4'b0010) begin errors++; $display("FAIL death_eb_clr got=%b exp=0010", eb_clr); end
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        checks++; if ({eb_clr, hit, health, dead} !== {4'b0, 1'b0, 3'd0, 1'b1}) begin errors++; $display("FAIL death_hold got=%b/%b/%0d/%b exp=0000/0/0/1", eb_clr, hit, health, dead); end
        eb_en = 4'b0000;
        restart = 1'b1;
        step();
        restart = 1'b0;
        checks++; if ({dead, health} !== {1'b0, 3'd3}) begin errors++; $display("FAIL death_restart got=%b/%0d exp=0/3", dead, health); end
        step();
        $display("test_death done health=%0d dead=%b", health, dead);
    endtask

    task automatic test_edge();
        pp_x = 10'd5; pp_y = 10'd3;
        set_bullet(2, 10'd0, 10'd0);
        eb_en = 4'b0100;
        step();
        eb_en = 4'b0000;
        checks++; if ({hit, eb_clr} !== 5'b10100) begin errors++; $display("FAIL edge_clamp got=%b/%b exp=1/0100", hit, eb_clr); end
        restart = 1'b1;
        step();
        restart = 1'b0;
        set_bullet(2, 10'd1023, 10'd0);
        eb_en = 4'b0100;
        step();
        eb_en = 4'b0000;
        checks++; if ({hit, eb_clr, health} !== {5'b0, 3'd3}) begin errors++; $display("FAIL edge_nowrap got=%b/%b/%0d exp=0/0000/3", hit, eb_clr, health); end
        step();
        $display("test_edge done health=%0d", health);
    endtask

    task automatic test_async_reset();
        eb_en = 4'b0100;
        set_bullet(2, 10'd10, 10'd10);
        step();
        eb_en = 4'b0000;
        step();
        run_ticks(43);
        checks++; if ({invuln, health} !== {1'b1, 3'd2}) begin errors++; $display("FAIL async_pre got=%b/%0d exp=1/2", invuln, health); end
        rst = 1'b1;
        #2;
        checks++; if ({invuln, flash, dead, hit} !== 4'b0000) begin errors++; $display("FAIL async_flags got=%b exp=0000", {invuln, flash, dead, hit}); end
        checks++; if (health !== 3'd3) begin errors++; $display("FAIL async_health got=%0d exp=3", health); end
        step();
        rst = 1'b0;
        step();
        eb_en = 4'b0100;
        step();
        eb_en = 4'b0000;
        checks++; if ({hit, invuln, health} !== {2'b11, 3'd2}) begin errors++; $display("FAIL post_reset_hit got=%b%b/%0d exp=11/2", hit, invuln, health); end
        $display("test_async_reset done health=%0d", health);
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_invuln_timer();
        test_restart_overlap();
        test_hit_tick();
        test_multi_hit();
        test_death();
        test_edge();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/player_hit_judge.md
PLAYER_HIT_JUDGE -- requirements
Module: player_hit_judge

Interface
REQ-001 SHALL have parameter HEALTH_INIT, 3, player health loaded at reset/restart (1..7).
REQ-002 SHALL have parameter INVULN_FRAMES, 60, invulnerability length in frame ticks (2..255).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port tick  input  1  one-cycle frame pulse.
REQ-006 SHALL have port restart  input  1  one-cycle pulse, new game.
REQ-007 SHALL have port pp_x, pp_y  input  10 each  player plane top-left position, pixels.
REQ-008 SHALL have port eb_x, eb_y  input  40 each  four enemy bullet positions, bullet i at bits [10i+9:10i].
REQ-009 SHALL have port eb_en  input  4  bit i = enemy bullet i exists.
REQ-010 SHALL have port eb_clr  output  4  registered one-cycle pulse, bit i = bullet i consumed, owner clears it.
REQ-011 SHALL have port health  output  3  current player health.
REQ-012 SHALL have port hit  output  1  registered one-cycle pulse on each damaging hit.
REQ-013 SHALL have port invuln  output  1  high while in INVULN.
REQ-014 SHALL have port flash  output  1  blink enable for player sprite.
REQ-015 SHALL have port dead  output  1  high while in DEAD.

Function
REQ-016 SHALL flag overlap[i] when eb_en[i] and pp_x-10 <= b_x < pp_x+50 and pp_y-10 <= b_y < pp_y+50, evaluated on current-cycle inputs.
REQ-017 SHALL compute bounds in 11-bit unsigned; lower bound clamps to 0 when pp_x<10 or pp_y<10; no 10-bit wrap.
REQ-018 SHALL implement states ALIVE, INVULN, DEAD, one state register.
REQ-019 ALIVE with any overlap: health decrements by exactly 1 regardless of how many bullets overlap; hit=1 next cycle.
REQ-020 ALIVE hit with health==1: next state DEAD, health 0; else next state INVULN, counter loaded with INVULN_FRAMES.
REQ-021 ALIVE: hit and tick in same cycle: hit wins; counter loaded with INVULN_FRAMES, tick ignored.
REQ-022 INVULN: counter decrements on each tick; tick with counter==1 -> ALIVE, counter 0.
REQ-023 INVULN: overlaps do not damage and assert no hit; overlap during the exit-tick cycle also does no damage.
REQ-024 ALIVE and INVULN: eb_clr[i] = overlap[i], registered, one cycle after the overlap cycle.
REQ-025 DEAD: eb_clr=0, hit=0, health held 0, ticks ignored.
REQ-026 SHALL hold health at 0 and never underflow.
REQ-027 flash SHALL equal counter[2] in INVULN and 0 in ALIVE/DEAD.
REQ-028 invuln and dead SHALL be registered state decodes with no combinational path from inputs.
REQ-029 restart in any state: next cycle ALIVE, health=HEALTH_INIT, counter 0, eb_clr=0, hit=0.
REQ-030 restart with a simultaneous overlap: restart wins; no damage, no eb_clr.

Reset
REQ-031 rst high: state ALIVE, health=HEALTH_INIT, counter 0, eb_clr=0, hit=0, invuln=0, flash=0, dead=0.
REQ-032 rst asserted mid-INVULN or in DEAD SHALL give the REQ-031 values immediately, without waiting for clk.
REQ-033 First overlap after rst release SHALL be judged as in ALIVE.

Verification
REQ-034 pp=(100,200), bullet0 at (120,230) with eb_en=0001 for 1 cycle -> next cycle eb_clr=0001, hit=1, health 3->2, invuln=1.
REQ-035 Bullets 1 and 3 overlap in the same cycle in ALIVE -> eb_clr=1010, health decrements by 1 only.
REQ-036 INVULN_FRAMES=60, 59 ticks -> still INVULN; 60th tick -> ALIVE; overlap at tick 30 -> eb_clr pulses, health unchanged.
REQ-037 health=1, overlap -> dead=1, health=0; later overlaps -> eb_clr=0; restart -> health=3, dead=0.
REQ-038 pp=(5,3), bullet at (0,0) -> hit; bullet at (1023,0) -> no hit (no wrap).
REQ-039 rst pulse mid-INVULN (counter=17) -> invuln=0, health=3 asynchronously.
